// File: rtl/conv_pkg.sv
// Shared defaults and types for the convolution result path.
// Holds word widths, the largest frame dimension and the streamer state enum.
package conv_pkg;

   localparam int DEF_IN_W       = 16;
   localparam int DEF_OUT_W      = 8;
   localparam int DEF_MAX_N      = 8;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   // Pixel count of an N x N frame; N never exceeds 8, so 7 bits hold 64.
   function automatic logic [6:0] frame_pixels(input logic [3:0] n);
      return {3'b000, n} * {3'b000, n};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word and full/empty flags.
// The head register is loaded directly from the write data when a word lands in an empty queue.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   input  logic         i_pop,
   output logic [W-1:0] o_head,
   output logic         o_full,
   output logic         o_empty
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [W-1:0]  r_head;

   logic          w_do_push;
   logic          w_do_pop;
   logic [AW-1:0] w_rd_ptr_next;
   logic [AW:0]   w_count_after_pop;
   logic [AW:0]   w_count_next;

   assign o_full  = (r_count == CNT_FULL);
   assign o_empty = (r_count == '0);
   assign o_head  = r_head;

   assign w_do_push         = i_push && !o_full;
   assign w_do_pop          = i_pop && !o_empty;
   assign w_rd_ptr_next     = r_rd_ptr + AW'(w_do_pop);
   assign w_count_after_pop = r_count - (AW+1)'(w_do_pop);
   assign w_count_next      = w_count_after_pop + (AW+1)'(w_do_push);

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         r_rd_ptr <= w_rd_ptr_next;
         r_count  <= w_count_next;
      end
   end

   // The new head is the pushed word only when the queue is empty after this pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= '0;
      end else if (w_count_next == '0) begin
         r_head <= '0;
      end else if (w_do_push && (w_count_after_pop == '0)) begin
         r_head <= i_wdata;
      end else begin
         r_head <= r_mem[w_rd_ptr_next];
      end
   end

endmodule

// File: rtl/result_streamer.sv
// Turns signed convolution results into saturated pixels and streams one N x N frame
// through a small FIFO, tagging end-of-row and end-of-frame on the output side.
module result_streamer
   import conv_pkg::*;
#(
   parameter int IN_W       = DEF_IN_W,
   parameter int OUT_W      = DEF_OUT_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int MAX_N      = DEF_MAX_N
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       size,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   input  logic             out_ready,
   output logic             out_eol,
   output logic             out_eof,
   output logic             busy,
   output logic             size_err
);

   localparam logic [3:0] MAX_N_L = 4'(MAX_N);

   state_t     r_state;
   state_t     w_state_next;
   logic [3:0] r_n;
   logic [6:0] r_push_cnt;
   logic [2:0] r_col;
   logic [2:0] r_row;
   logic       r_size_err;

   logic             w_size_ok;
   logic             w_accept;
   logic             w_reject;
   logic             w_push;
   logic             w_pop;
   logic             w_last_push;
   logic             w_col_last;
   logic             w_row_last;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [OUT_W-1:0] w_conv;

   sync_fifo #(
      .W     (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (w_conv),
      .i_pop   (w_pop),
      .o_head  (out_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // Negative clamps to 0; anything above the OUT_W range clamps to all ones.
   always_comb begin
      if (in_data[IN_W-1]) begin
         w_conv = '0;
      end else if (|in_data[IN_W-2:OUT_W]) begin
         w_conv = '1;
      end else begin
         w_conv = in_data[OUT_W-1:0];
      end
   end

   assign w_size_ok   = (size != 4'd0) && (size <= MAX_N_L);
   assign in_ready    = (r_state == STREAM) && !w_fifo_full;
   assign w_push      = in_valid && in_ready;
   assign out_valid   = !w_fifo_empty;
   assign w_pop       = out_valid && out_ready;
   assign w_last_push = (r_push_cnt == frame_pixels(r_n) - 7'd1);
   assign w_col_last  = ({1'b0, r_col} == r_n - 4'd1);
   assign w_row_last  = ({1'b0, r_row} == r_n - 4'd1);
   assign out_eol     = out_valid && w_col_last;
   assign out_eof     = out_eol && w_row_last;
   assign busy        = (r_state != IDLE);
   assign size_err    = r_size_err;

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_reject     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (w_size_ok) begin
                  w_accept     = 1'b1;
                  w_state_next = STREAM;
               end else begin
                  w_reject = 1'b1;
               end
            end
         end
         STREAM: begin
            if (w_push && w_last_push) begin
               w_state_next = DRAIN;
            end
         end
         DRAIN: begin
            // The eof pixel is always the last word pushed, so it can only leave in DRAIN.
            if (w_pop && out_eof) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_n        <= '0;
         r_push_cnt <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_size_err <= 1'b0;
      end else begin
         r_size_err <= w_reject;
         if (w_accept) begin
            r_n        <= size;
            r_push_cnt <= '0;
            r_col      <= '0;
            r_row      <= '0;
         end else begin
            if (w_push) begin
               r_push_cnt <= r_push_cnt + 7'd1;
            end
            if (w_pop) begin
               if (w_col_last) begin
                  r_col <= '0;
                  r_row <= r_row + 3'd1;
               end else begin
                  r_col <= r_col + 3'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_result_streamer.sv
// Randomized frame-level bench for result_streamer with a queue-based pixel model.
module tb_result_streamer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  size;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        out_eol;
   logic        out_eof;
   logic        busy;
   logic        size_err;

   int n_checks = 0;
   int n_pass   = 0;
   int src_q[$];

   always #5 clk = ~clk;

   result_streamer #(
      .IN_W       (16),
      .OUT_W      (8),
      .FIFO_DEPTH (DEPTH),
      .MAX_N      (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .size      (size),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .out_eol   (out_eol),
      .out_eof   (out_eof),
      .busy      (busy),
      .size_err  (size_err)
   );

   function automatic int sat(input int x);
      if (x < 0) return 0;
      if (x > 255) return 255;
      return x;
   endfunction

   function automatic int rand_word();
      int edges[6];
      edges = '{-1, 0, 255, 256, -32768, 32767};
      case ($urandom_range(0, 3))
         0: return int'($signed(16'($urandom)));
         1: return int'($urandom_range(0, 255));
         2: return edges[$urandom_range(0, 5)];
         default: return int'($urandom_range(0, 900)) - 300;
      endcase
   endfunction

   task automatic fill_random(input int count);
      src_q.delete();
      for (int i = 0; i < count; i++) src_q.push_back(rand_word());
   endtask

   task automatic check_all_zero(input string name);
      logic [13:0] outs;
      outs = {out_valid, out_data, out_eol, out_eof, in_ready, busy, size_err};
      n_checks++;
      if (outs !== 14'd0)
         $display("FAIL %s: outputs {valid,data,eol,eof,in_ready,busy,size_err}=%b required all 0", name, outs);
      else
         n_pass++;
   endtask

   task automatic do_start(input logic [3:0] s);
      start = 1'b1;
      size  = s;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Runs one frame of n*n words from src_q; the model tracks occupancy and pixel order.
   task automatic run_frame(input int n, input int valid_pct, input int ready_pct,
                            input int hold, input int abort_at, input bit poke);
      int total;
      int pushes;
      int pops;
      int occ;
      int cyc;
      int exp_data;
      bit exp_ready;
      bit exp_eol;
      bit exp_eof;
      bit push_now;
      bit pop_now;
      bit aborted;
      total = n * n;
      pushes = 0; pops = 0; occ = 0; cyc = 0; aborted = 1'b0;
      do_start(4'(n));
      while (pops < total && cyc < 4000) begin
         exp_ready = (pushes < total) && (occ < DEPTH);
         n_checks++;
         if (in_ready !== exp_ready)
            $display("FAIL in_ready n=%0d cyc=%0d: got %b required %b", n, cyc, in_ready, exp_ready);
         else n_pass++;
         n_checks++;
         if (out_valid !== (occ > 0))
            $display("FAIL out_valid n=%0d cyc=%0d: got %b required %b", n, cyc, out_valid, occ > 0);
         else n_pass++;
         n_checks++;
         if (busy !== 1'b1)
            $display("FAIL busy n=%0d cyc=%0d: got %b required 1", n, cyc, busy);
         else n_pass++;
         if (occ > 0) begin
            exp_data = sat(src_q[pops]);
            exp_eol  = ((pops % n) == n - 1);
            exp_eof  = (pops == total - 1);
            n_checks++;
            if (out_data !== 8'(exp_data))
               $display("FAIL out_data n=%0d pixel=%0d: got %0d required %0d", n, pops, out_data, exp_data);
            else n_pass++;
            n_checks++;
            if (out_eol !== exp_eol)
               $display("FAIL out_eol n=%0d pixel=%0d: got %b required %b", n, pops, out_eol, exp_eol);
            else n_pass++;
            n_checks++;
            if (out_eof !== exp_eof)
               $display("FAIL out_eof n=%0d pixel=%0d: got %b required %b", n, pops, out_eof, exp_eof);
            else n_pass++;
         end
         in_valid  = ($urandom_range(0, 99) < valid_pct);
         in_data   = (pushes < total) ? 16'(src_q[pushes]) : 16'($urandom);
         out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
         if (poke) begin
            start = 1'($urandom_range(0, 1));
            size  = 4'($urandom_range(1, 15));
         end
         push_now = in_valid && exp_ready;
         pop_now  = out_ready && (occ > 0);
         @(posedge clk); #1;
         pushes += int'(push_now);
         pops   += int'(pop_now);
         occ    = occ + int'(push_now) - int'(pop_now);
         cyc++;
         if (abort_at > 0 && pushes == abort_at) begin
            aborted = 1'b1;
            break;
         end
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      if (!aborted) begin
         n_checks++;
         if (pops != total)
            $display("FAIL frame_timeout n=%0d: got %0d pixels required %0d", n, pops, total);
         else n_pass++;
         n_checks++;
         if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL end_idle n=%0d: busy=%b out_valid=%b required 0 0", n, busy, out_valid);
         else n_pass++;
         $display("frame n=%0d pixels=%0d cycles=%0d", n, pops, cyc);
      end else begin
         $display("frame n=%0d aborted after %0d pushes", n, pushes);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; size = 4'd2; in_valid = 1'b1; in_data = 16'd7; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_during");
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      check_all_zero("reset_after");
   endtask

   task automatic test_basic();
      src_q.delete();
      src_q = '{10, -5, 300, 255};
      run_frame(2, 100, 100, 0, 0, 1'b0);
   endtask

   task automatic test_size_err();
      logic [3:0] bad[3];
      bad = '{4'd0, 4'd9, 4'd15};
      foreach (bad[i]) begin
         do_start(bad[i]);
         n_checks++;
         if (size_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL size_err_pulse size=%0d: err=%b busy=%b in_ready=%b required 1 0 0",
                     bad[i], size_err, busy, in_ready);
         else n_pass++;
         @(posedge clk); #1;
         n_checks++;
         if (size_err !== 1'b0 || busy !== 1'b0)
            $display("FAIL size_err_single size=%0d: err=%b busy=%b required 0 0", bad[i], size_err, busy);
         else n_pass++;
         $display("start size=%0d rejected", bad[i]);
      end
   endtask

   task automatic test_backpressure();
      fill_random(9);
      run_frame(3, 100, 100, 8, 0, 1'b0);
   endtask

   task automatic test_single();
      src_q.delete();
      src_q.push_back(128);
      run_frame(1, 100, 100, 0, 0, 1'b0);
   endtask

   task automatic test_mid_reset();
      fill_random(16);
      run_frame(4, 100, 100, 0, 5, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      check_all_zero("mid_reset_during");
      rst = 1'b0;
      @(posedge clk); #1;
      check_all_zero("mid_reset_after");
      fill_random(4);
      run_frame(2, 100, 100, 0, 0, 1'b0);
   endtask

   task automatic test_random_frame();
      fill_random(64);
      run_frame(8, 70, 50, 0, 0, 1'b1);
   endtask

   task automatic test_back_to_back();
      int n;
      for (int f = 0; f < 6; f++) begin
         n = $urandom_range(1, 8);
         fill_random(n * n);
         run_frame(n, $urandom_range(40, 100), $urandom_range(30, 100), 0, 0, 1'b1);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_size_err();
      test_backpressure();
      test_single();
      test_mid_reset();
      test_random_frame();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/result_streamer.md
RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 Parameter IN_W, 16, width of signed convolution result word.
REQ-002 Parameter OUT_W, 8, width of unsigned output pixel.
REQ-003 Parameter FIFO_DEPTH, 4, result FIFO entries (power of two).
REQ-004 Parameter MAX_N, 8, largest supported matrix dimension.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle request to begin a frame.
REQ-008 size  in  4  matrix dimension N, sampled with start.
REQ-009 in_valid  in  1  convolution result available.
REQ-010 in_data  in  IN_W  signed two's-complement result.
REQ-011 in_ready  out  1  block accepts in_data this cycle.
REQ-012 out_valid  out  1  out_data valid.
REQ-013 out_data  out  OUT_W  saturated pixel.
REQ-014 out_ready  in  1  downstream accepts out_data.
REQ-015 out_eol  out  1  qualifies last pixel of a row.
REQ-016 out_eof  out  1  qualifies last pixel of the frame.
REQ-017 busy  out  1  frame in progress.
REQ-018 size_err  out  1  one-cycle pulse on rejected start.

Function
REQ-019 States SHALL be IDLE, STREAM, DRAIN; busy SHALL be 1 in STREAM and DRAIN.
REQ-020 IDLE + start with 1<=size<=MAX_N SHALL latch N=size, clear all counters, enter STREAM next cycle.
REQ-021 IDLE + start with size 0 or >MAX_N SHALL pulse size_err for exactly one cycle and remain IDLE.
REQ-022 start outside IDLE SHALL be ignored; latched N SHALL not change mid-frame.
REQ-023 in_ready SHALL be 1 only in STREAM with FIFO not full; a push SHALL occur when in_valid&&in_ready.
REQ-024 in_ready SHALL be 0 when FIFO full even if a pop occurs that cycle.
REQ-025 Each pushed word SHALL be converted before storage: <0 -> 0, >255 -> 255, else low OUT_W bits.
REQ-026 After N*N pushes STREAM SHALL go to DRAIN; in_ready SHALL be 0 in DRAIN and IDLE.
REQ-027 out_valid SHALL equal FIFO not empty; out_data SHALL be FIFO head; a pop SHALL occur when out_valid&&out_ready.
REQ-028 Word pushed at edge t SHALL appear on out_valid/out_data after edge t (one-cycle latency into empty FIFO).
REQ-029 out_data, out_eol, out_eof SHALL hold stable while out_valid&&!out_ready.
REQ-030 Output column/row counters (3 bits each) SHALL advance on pop only, column wrapping at N-1 and row incrementing.
REQ-031 out_eol SHALL be 1 when out_valid and column==N-1; out_eof SHALL be 1 when out_valid and column==N-1 and row==N-1.
REQ-032 Simultaneous push and pop SHALL leave FIFO occupancy unchanged and preserve order.
REQ-033 Pop of the eof pixel SHALL return to IDLE next cycle; a start in that same cycle SHALL be ignored.
REQ-034 N=1 SHALL assert out_eol and out_eof together on the single pixel.

Reset
REQ-035 rst SHALL force IDLE, empty FIFO, all counters 0, N=0.
REQ-036 During and after reset out_valid, out_data, out_eol, out_eof, in_ready, busy, size_err SHALL be 0.
REQ-037 rst mid-frame SHALL discard all buffered pixels with no further output.

Structure
REQ-038 Shared package conv_pkg SHALL hold IN_W, OUT_W, MAX_N defaults and the state enum (IDLE, STREAM, DRAIN).
REQ-039 FIFO SHALL be a separate sub-module sync_fifo (registered head, full/empty flags); conversion and counters remain in result_streamer.

Verification
REQ-040 start, size=2, in_data 10,-5,300,255, out_ready=1 -> out_data 10,0,255,255; eol on 2nd and 4th; eof on 4th; IDLE after.
REQ-041 start, size=0 and size=9 -> size_err single-cycle pulse each, busy stays 0, in_ready stays 0.
REQ-042 size=3, in_valid held 1, out_ready=0 -> exactly 4 pushes then in_ready=0; out_data holds first pixel; releasing out_ready drains 9 pixels in order.
REQ-043 size=1, in_data 128 -> single pixel 128 with out_eol=out_eof=1, busy falls next cycle.
REQ-044 size=4, rst asserted after 5 pushes -> next cycle all outputs 0; new start size=2 streams correctly.
REQ-045 size=8, random out_ready 50% -> 64 pixels in order, 8 eol, 1 eof, no loss or duplicate.
